// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a serial bit-stream detector.
// A one-word holding buffer lets consecutive words stream with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [WIDTH-1:0] hold_buf;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             buf_full, buf_full_nx;
  logic             load_hold;
  logic             accept;
  logic             last_bit;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign din_ready = !buf_full && !rst;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (state == SHIFT) && (cnt == LAST);

  // Outputs depend on registers only; gating with the state keeps ser_out at 0 when idle.
  assign ser_valid = (state == SHIFT);
  assign ser_last  = last_bit;
  assign ser_out   = (state == SHIFT) && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);

  always_comb begin
    state_nx    = state;
    sh_nx       = sh;
    cnt_nx      = cnt;
    buf_full_nx = buf_full;
    load_hold   = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        sh_nx    = din;
        cnt_nx   = '0;
        state_nx = SHIFT;
      end
    end else if (!last_bit) begin
      sh_nx  = shift_one(sh);
      cnt_nx = cnt + 1'b1;
      if (accept) begin
        load_hold   = 1'b1;
        buf_full_nx = 1'b1;
      end
    end else begin
      // Last bit: buffered word wins over a fresh din, so words never reorder.
      cnt_nx = '0;
      if (buf_full) begin
        sh_nx       = hold_buf;
        buf_full_nx = 1'b0;
      end else if (accept) begin
        sh_nx = din;
      end else begin
        sh_nx    = shift_one(sh);
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      buf_full <= 1'b0;
      sh       <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      buf_full <= buf_full_nx;
      sh       <= sh_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (load_hold) hold_buf <= din;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus randomized traffic against a
// word-queue reference model; a small "111" detector observes the serial stream.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;

  logic [7:0] din_l;
  logic       valid_l;
  logic       ready_l;
  logic       ser_out_l;
  logic       ser_valid_l;
  logic       ser_last_l;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(valid_l), .din_ready(ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_last(ser_last_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream overlapping "111" Mealy detector watching the MSB-first stream.
  logic h1, h2, det;
  always @(posedge clk) begin
    if (rst) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
    end else begin
      h2 <= h1;
      h1 <= ser_out;
    end
  end
  assign det = ser_out && h1 && h2;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_valid = 1'b1;
    din = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", din_ready); end
      checks++;
      if ({ser_out, ser_valid, ser_last} !== 3'b000) begin
        errors++; $display("FAIL reset_outputs: got %b want 000", {ser_out, ser_valid, ser_last});
      end
    end
    din_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", din_ready); end
    tick();
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hE7;
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== w[8-i] || ser_last !== (i == 8)) begin
        errors++;
        $display("FAIL single_c%0d: got v=%b o=%b l=%b want v=1 o=%b l=%b",
                 i, ser_valid, ser_out, ser_last, w[8-i], (i == 8));
      end
      tick();
    end
    checks++;
    if ({ser_out, ser_valid, ser_last} !== 3'b000) begin
      errors++; $display("FAIL single_end: got %b want 000", {ser_out, ser_valid, ser_last});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic        acc;
    int          idx;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    stream = {8'hA5, 8'h3C, 8'hFF};
    idx = 0;
    din = words[0];
    din_valid = 1'b1;
    for (int i = 0; i <= 25; i++) begin
      if (i >= 1 && i <= 16) begin
        checks++;
        if (din_ready !== (i == 1 || i == 9)) begin
          errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", i, din_ready, (i == 1 || i == 9));
        end
      end
      if (i >= 1 && i <= 24) begin
        checks++;
        if (ser_valid !== 1'b1 || ser_out !== stream[24-i] || ser_last !== (i % 8 == 0)) begin
          errors++;
          $display("FAIL b2b_bit_c%0d: got v=%b o=%b l=%b want v=1 o=%b l=%b",
                   i, ser_valid, ser_out, ser_last, stream[24-i], (i % 8 == 0));
        end
      end
      if (i == 25) begin
        checks++;
        if (ser_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got v=%b want 0", ser_valid); end
      end
      acc = din_valid && din_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) din = words[idx];
        else din_valid = 1'b0;
      end
    end
  endtask

  task automatic test_lsb();
    din_l = 8'h01;
    valid_l = 1'b1;
    tick();
    valid_l = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (ser_valid_l !== 1'b1 || ser_out_l !== (i == 1) || ser_last_l !== (i == 8)) begin
        errors++;
        $display("FAIL lsb_c%0d: got v=%b o=%b l=%b want v=1 o=%b l=%b",
                 i, ser_valid_l, ser_out_l, ser_last_l, (i == 1), (i == 8));
      end
      tick();
    end
    checks++;
    if (ser_valid_l !== 1'b0 || ser_out_l !== 1'b0) begin
      errors++; $display("FAIL lsb_end: got v=%b o=%b want 0 0", ser_valid_l, ser_out_l);
    end
  endtask

  task automatic test_reset_mid();
    din = 8'hFF;
    din_valid = 1'b1;
    tick();
    din = 8'hAA;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (ser_valid !== 1'b1 || ser_out !== 1'b1) begin
      errors++; $display("FAIL mid_bit4: got v=%b o=%b want 1 1", ser_valid, ser_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({ser_out, ser_valid, ser_last} !== 3'b000) begin
        errors++; $display("FAIL mid_flush_c%0d: got %b want 000", i, {ser_out, ser_valid, ser_last});
      end
      tick();
    end
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", din_ready); end
  endtask

  task automatic test_detector();
    logic [7:0] words [2];
    logic       acc;
    int         idx;
    din = 8'b0111_0000;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (det !== (i == 4)) begin errors++; $display("FAIL det_single_c%0d: got %b want %b", i, det, (i == 4)); end
      tick();
    end
    words[0] = 8'hFF; words[1] = 8'h00;
    idx = 0;
    din = words[0];
    din_valid = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      if (i >= 1) begin
        checks++;
        if (det !== (i >= 3 && i <= 8)) begin
          errors++; $display("FAIL det_pair_c%0d: got %b want %b", i, det, (i >= 3 && i <= 8));
        end
      end
      acc = din_valid && din_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 2) din = words[idx];
        else din_valid = 1'b0;
      end
    end
  endtask

  // Reference: current word with a count of bits still to send, plus a queue of waiting words.
  task automatic test_random();
    int         rem;
    logic [7:0] cur;
    logic [7:0] pend [$];
    logic       acc;
    logic       exp_out;
    rem = 0;
    cur = 8'h00;
    din_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!din_valid && n < 370) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din = 8'($urandom);
      end
      exp_out = (rem > 0) ? cur[rem-1] : 1'b0;
      checks++;
      if (din_ready !== (pend.size() == 0)) begin
        errors++; $display("FAIL rnd_ready_n%0d: got %b want %b", n, din_ready, (pend.size() == 0));
      end
      checks++;
      if (ser_valid !== (rem > 0) || ser_out !== exp_out || ser_last !== (rem == 1)) begin
        errors++;
        $display("FAIL rnd_out_n%0d: got v=%b o=%b l=%b want v=%b o=%b l=%b",
                 n, ser_valid, ser_out, ser_last, (rem > 0), exp_out, (rem == 1));
      end
      acc = din_valid && (pend.size() == 0);
      tick();
      if (rem > 1) begin
        rem--;
        if (acc) pend.push_back(din);
      end else if (pend.size() > 0) begin
        cur = pend.pop_front();
        rem = 8;
      end else if (acc) begin
        cur = din;
        rem = 8;
      end else begin
        rem = 0;
      end
      if (acc) din_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    din_l = 8'h00;
    valid_l = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb();
    test_reset_mid();
    test_detector();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the serial "111" Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out, which feeds the detector's 1-bit data input.
- A one-word holding buffer lets consecutive words stream with no idle bit between them.
- ser_out is forced to 0 whenever no word is being shifted, so the detector sees no spurious ones.

Parameters:
- WIDTH, 8, word width in bits; legal range is 2 to 32.
- MSB_FIRST, 1, bit order: 1 sends din[WIDTH-1] first, 0 sends din[0] first.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- din  in  WIDTH  parallel word; sampled only on the accepting edge.
- din_valid  in  1  upstream has a word on din.
- din_ready  out  1  block can take a word; equals !buf_full && !rst (combinational from registers).
- ser_out  out  1  current serial bit, registered; 0 when ser_valid=0.
- ser_valid  out  1  ser_out carries a live data bit, registered.
- ser_last  out  1  high while the final bit of a word is on ser_out, registered.

Behaviour:
- Internal state:
  - State machine with two states, IDLE and SHIFT.
  - Shift register sh[WIDTH-1:0].
  - Bit counter cnt, $clog2(WIDTH) bits wide.
  - Holding buffer buf[WIDTH-1:0] with flag buf_full.
- Accept: a word is accepted on an edge where din_valid=1 and din_ready=1. din_valid with din_ready=0 has no effect; upstream must hold din stable until it is accepted.
- Reset (rst high at an edge):
  - state=IDLE, cnt=0, buf_full=0, sh=0.
  - ser_out=0, ser_valid=0, ser_last=0.
  - din_ready=0 while rst is high.
  - Reset mid-word discards the partial word and any buffered word; nothing further is emitted.
- IDLE:
  - ser_valid=0 and ser_out=0.
  - On accept: sh<=din, cnt<=0, go to SHIFT.
  - First bit appears on ser_out in the cycle after the accepting edge, so latency is 1 cycle.
- SHIFT, not last bit (cnt<WIDTH-1):
  - Shift sh toward the output end by one bit; cnt<=cnt+1.
  - On accept: buf<=din, buf_full<=1.
- SHIFT, last bit (cnt==WIDTH-1), with ser_last=1 this cycle. At the edge, in priority order:
  - If buf_full: sh<=buf, buf_full<=0, cnt<=0, stay in SHIFT.
  - Else on accept: sh<=din, cnt<=0, stay in SHIFT.
  - Else: go to IDLE; ser_valid=0 in the following cycle.
  - In all three cases no bubble appears between words when the next word is available.
- Simultaneous events:
  - Last-bit edge with buf_full=1: din_ready=0, so a new din is not taken; it is accepted on the next edge instead, into buf.
  - Accept on a mid-word edge with buf_full=0 fills buf.
- Output bit select:
  - MSB_FIRST=1: ser_out is sh[WIDTH-1] and sh shifts left, filling with 0.
  - MSB_FIRST=0: ser_out is sh[0] and sh shifts right, filling with 0.
- Throughput: exactly WIDTH cycles per word. ser_valid stays continuously high while words keep arriving.
- Invariants: ser_last implies ser_valid; ser_out=0 whenever ser_valid=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with din_valid=1 -> din_ready=0; ser_out, ser_valid and ser_last all 0. Release rst -> din_ready=1.
- Single word, WIDTH=8, MSB_FIRST=1: accept din=8'hE7 at edge 0 -> cycles 1..8 show ser_out=1,1,1,0,0,1,1,1 with ser_valid=1. ser_last=1 in cycle 8 only. ser_valid=0 from cycle 9.
- Back-to-back: din_valid held high with words A=8'hA5, B=8'h3C, C=8'hFF ->
  - 24 contiguous ser_valid cycles carrying A, B, C in order.
  - din_ready drops after B is buffered and rises for one cycle after each last-bit edge.
- LSB-first: MSB_FIRST=0, din=8'h01 -> ser_out=1 in cycle 1, then seven 0s.
- Reset mid-word: assert rst during the 4th bit of 8'hFF with a second word buffered -> ser_valid=0 and ser_out=0 from the next cycle; neither the buffered word nor the rest of 8'hFF is emitted.
- Integration with the detector: feed 8'b0111_0000 (MSB-first) -> detector out=1 exactly once, on the third consecutive 1 (cycle 4). Words 8'hFF then 8'h00 back-to-back -> detector out stays high from cycle 3 through cycle 8, then goes low.
